// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, Val2 generator, ALU, NZCV register, branch target, EXE/MEM register.
// Latency: 1 cycle to the EXE/MEM outputs; branch_taken/branch_addr are combinational.
// Backpressure: freeze holds the EXE/MEM register and the status register; nothing is dropped.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             WB_en_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             imm_in,
  input  logic             branch_in,
  input  logic             s_in,
  input  logic             carry_in,
  input  logic [3:0]       EXE_cmd_in,
  input  logic [3:0]       dest_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] Val_Rn_in,
  input  logic [WIDTH-1:0] Val_Rm_in,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic [3:0]       status_out,
  output logic             WB_en_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [3:0]       dest_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] Val_Rm_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [31:0] op_a;
  logic [31:0] rm_fwd;
  logic [31:0] val2;
  logic [63:0] rot_tmp;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        wb_en_q, wb_en_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic [3:0]  status_q, status_d;

  // Forwarding muxes; code 11 falls back to the register value like 00.
  always_comb begin
    op_a   = Val_Rn_in;
    rm_fwd = Val_Rm_in;
    case (sel_src1)
      2'b01:   op_a = mem_fwd_val;
      2'b10:   op_a = wb_fwd_val;
      default: op_a = Val_Rn_in;
    endcase
    case (sel_src2)
      2'b01:   rm_fwd = mem_fwd_val;
      2'b10:   rm_fwd = wb_fwd_val;
      default: rm_fwd = Val_Rm_in;
    endcase
  end

  // Val2: rotated immediate, then memory offset, then shifted register.
  always_comb begin
    rot_amt = {shift_operand_in[11:8], 1'b0};
    sh_amt  = shift_operand_in[11:7];
    rot_tmp = 64'd0;
    val2    = rm_fwd;
    if (imm_in) begin
      rot_tmp = {24'd0, shift_operand_in[7:0], 24'd0, shift_operand_in[7:0]} >> rot_amt;
      val2    = rot_tmp[31:0];
    end else if (mem_read_in || mem_write_in) begin
      val2 = {20'd0, shift_operand_in};
    end else if (sh_amt != 5'd0) begin
      case (shift_operand_in[6:5])
        2'b00: val2 = rm_fwd << sh_amt;
        2'b01: val2 = rm_fwd >> sh_amt;
        2'b10: val2 = $signed(rm_fwd) >>> sh_amt;
        default: begin
          rot_tmp = {rm_fwd, rm_fwd} >> sh_amt;
          val2    = rot_tmp[31:0];
        end
      endcase
    end
  end

  // ALU with shared adder; subtraction is A + ~Val2 + carry so C means "no borrow".
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    case (EXE_cmd_in)
      CMD_ADC: add_cin = carry_in;
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;     end
      CMD_SBC: begin add_b = ~val2; add_cin = carry_in; end
      default: ;
    endcase
    sum = {1'b0, op_a} + {1'b0, add_b} + {32'd0, add_cin};

    result = 32'd0;
    case (EXE_cmd_in)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result = sum[31:0];
      CMD_AND: result = op_a & val2;
      CMD_ORR: result = op_a | val2;
      CMD_EOR: result = op_a ^ val2;
      default: result = 32'd0;
    endcase

    // C and V are only produced by the arithmetic group; everything else keeps them.
    flags = {result[31], (result == 32'd0), status_q[1], status_q[0]};
    case (EXE_cmd_in)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        flags[1] = sum[32];
        flags[0] = (op_a[31] == add_b[31]) && (result[31] != op_a[31]);
      end
      default: ;
    endcase
  end

  // Next state for the EXE/MEM register and NZCV register.
  always_comb begin
    wb_en_d      = wb_en_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    dest_d       = dest_q;
    alu_result_d = alu_result_q;
    val_rm_d     = val_rm_q;
    status_d     = status_q;
    if (!freeze) begin
      wb_en_d      = WB_en_in;
      mem_read_d   = mem_read_in;
      mem_write_d  = mem_write_in;
      dest_d       = dest_in;
      alu_result_d = result;
      val_rm_d     = rm_fwd;
      if (s_in) status_d = flags;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      dest_q       <= 4'd0;
      alu_result_q <= 32'd0;
      val_rm_q     <= 32'd0;
      status_q     <= 4'd0;
    end else begin
      wb_en_q      <= wb_en_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      dest_q       <= dest_d;
      alu_result_q <= alu_result_d;
      val_rm_q     <= val_rm_d;
      status_q     <= status_d;
    end
  end

  // Branch resolution is combinational so IF/ID can flush this cycle.
  assign branch_taken = branch_in;
  assign branch_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

  assign status_out     = status_q;
  assign WB_en_out      = wb_en_q;
  assign mem_read_out   = mem_read_q;
  assign mem_write_out  = mem_write_q;
  assign dest_out       = dest_q;
  assign alu_result_out = alu_result_q;
  assign Val_Rm_out     = val_rm_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for single-cycle ops, hand sequences for freeze/branch/reset.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        WB_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_in;
  logic [3:0]  EXE_cmd_in, dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_in;
  logic [31:0] pc_in, Val_Rn_in, Val_Rm_in, mem_fwd_val, wb_fwd_val;
  logic [1:0]  sel_src1, sel_src2;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  logic        WB_en_out, mem_read_out, mem_write_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_result_out, Val_Rm_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_en_in(WB_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .imm_in(imm_in), .branch_in(branch_in), .s_in(s_in), .carry_in(carry_in),
    .EXE_cmd_in(EXE_cmd_in), .dest_in(dest_in), .shift_operand_in(shift_operand_in),
    .signed_imm_in(signed_imm_in), .pc_in(pc_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status_out(status_out),
    .WB_en_out(WB_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .dest_out(dest_out), .alu_result_out(alu_result_out), .Val_Rm_out(Val_Rm_out)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic        imm, mr, mw, wb, s, cin;
    logic [11:0] sop;
    logic [31:0] rn, rm;
    logic [1:0]  s1, s2;
    logic [31:0] mf, wf;
    logic [3:0]  dest;
    logic [31:0] e_alu;
    logic [3:0]  e_st;
    logic [31:0] e_rm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    EXE_cmd_in = v.cmd; imm_in = v.imm; mem_read_in = v.mr; mem_write_in = v.mw;
    WB_en_in = v.wb; s_in = v.s; carry_in = v.cin; shift_operand_in = v.sop;
    Val_Rn_in = v.rn; Val_Rm_in = v.rm; sel_src1 = v.s1; sel_src2 = v.s2;
    mem_fwd_val = v.mf; wb_fwd_val = v.wf; dest_in = v.dest;
  endtask

  initial begin
    // cmd imm mr mw wb s cin sop rn rm s1 s2 mf wf dest | alu status valrm
    vecs[0]  = '{4'h2,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,12'h001,32'h7FFFFFFF,32'h0,2'd0,2'd0,32'h0,32'h0,4'h3, 32'h80000000,4'b1001,32'h0};
    vecs[1]  = '{4'h1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,12'h4FF,32'h0,32'h0,2'd0,2'd0,32'h0,32'h0,4'h1, 32'hFF000000,4'b1001,32'h0};
    vecs[2]  = '{4'h1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,12'h240,32'h0,32'h80000010,2'd0,2'd0,32'h0,32'h0,4'h2, 32'hF8000001,4'b1001,32'h80000010};
    vecs[3]  = '{4'h2,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,12'hFFF,32'h1000,32'h0,2'd0,2'd0,32'h0,32'h0,4'h5, 32'h00001FFF,4'b1001,32'h0};
    vecs[4]  = '{4'h4,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,12'h003,32'h0,32'h0,2'd1,2'd0,32'h5,32'h0,4'h6, 32'h2,4'b0010,32'h0};
    vecs[5]  = '{4'h2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h004,32'h2000,32'h11111111,2'd0,2'd2,32'h0,32'hDEADBEEF,4'h7, 32'h2004,4'b0010,32'hDEADBEEF};
    vecs[6]  = '{4'h3,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,12'h001,32'hFFFFFFFF,32'h0,2'd0,2'd0,32'h0,32'h0,4'h8, 32'h1,4'b0010,32'h0};
    vecs[7]  = '{4'h5,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,12'h005,32'h5,32'h0,2'd0,2'd0,32'h0,32'h0,4'h9, 32'hFFFFFFFF,4'b1000,32'h0};
    vecs[8]  = '{4'h4,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,12'h007,32'h7,32'h0,2'd0,2'd0,32'h0,32'h0,4'h0, 32'h0,4'b0110,32'h0};
    vecs[9]  = '{4'h6,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,12'h000,32'hF0F0F0F0,32'h0FF00FF0,2'd0,2'd0,32'h0,32'h0,4'hA, 32'h00F000F0,4'b0010,32'h0FF00FF0};
    vecs[10] = '{4'h7,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,12'h200,32'h1,32'h1,2'd0,2'd0,32'h0,32'h0,4'hB, 32'h11,4'b0010,32'h1};
    vecs[11] = '{4'h8,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,12'hFA0,32'hFFFFFFFF,32'h80000000,2'd0,2'd0,32'h0,32'h0,4'hC, 32'hFFFFFFFE,4'b1010,32'h80000000};
    vecs[12] = '{4'h9,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,12'h260,32'h0,32'hF1,2'd0,2'd0,32'h0,32'h0,4'hD, 32'hEFFFFFF0,4'b1010,32'hF1};
    vecs[13] = '{4'hA,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,12'h000,32'h12345678,32'h0,2'd0,2'd0,32'h0,32'h0,4'hE, 32'h0,4'b0110,32'h0};
    vecs[14] = '{4'h0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,32'h0,32'h0,2'd0,2'd0,32'h0,32'h0,4'h0, 32'h0,4'b0110,32'h0};
    vecs[15] = '{4'h2,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,12'h001,32'h10,32'h55,2'd3,2'd3,32'h99,32'h77,4'hF, 32'h11,4'b0110,32'h55};

    rst = 1'b0; freeze = 1'b0; branch_in = 1'b0; signed_imm_in = 24'd0; pc_in = 32'd0;
    apply(vecs[14]);
    #3;
    chk("reset_alu", alu_result_out, 32'h0);
    chk("reset_status", {28'd0, status_out}, 32'h0);
    chk("reset_ctrl", {25'd0, WB_en_out, mem_read_out, mem_write_out, dest_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].e_alu);
      chk($sformatf("v%0d_status", i), {28'd0, status_out}, {28'd0, vecs[i].e_st});
      chk($sformatf("v%0d_ctrl", i), {25'd0, WB_en_out, mem_read_out, mem_write_out, dest_out},
          {25'd0, vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].dest});
      chk($sformatf("v%0d_valrm", i), Val_Rm_out, vecs[i].e_rm);
    end

    // Freeze with s=1: nothing moves; branch still resolves combinationally.
    freeze = 1'b1;
    apply(vecs[0]);
    branch_in = 1'b1; pc_in = 32'h100; signed_imm_in = 24'hFFFFFE;
    #1;
    chk("br_taken", {31'd0, branch_taken}, 32'h1);
    chk("br_addr_back", branch_addr, 32'hF8);
    @(posedge clk); #1;
    chk("frz_alu", alu_result_out, 32'h11);
    chk("frz_status", {28'd0, status_out}, 32'h6);
    chk("frz_ctrl", {25'd0, WB_en_out, mem_read_out, mem_write_out, dest_out}, 32'h4F);
    chk("frz_valrm", Val_Rm_out, 32'h55);
    pc_in = 32'hFFFFFFFC; signed_imm_in = 24'h000002; branch_in = 1'b0;
    #1;
    chk("br_addr_wrap", branch_addr, 32'h4);
    chk("br_not_taken", {31'd0, branch_taken}, 32'h0);

    // Asynchronous reset mid-cycle while frozen.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_alu", alu_result_out, 32'h0);
    chk("arst_status", {28'd0, status_out}, 32'h0);
    chk("arst_ctrl", {25'd0, WB_en_out, mem_read_out, mem_write_out, dest_out}, 32'h0);
    chk("arst_valrm", Val_Rm_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; freeze = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_alu", alu_result_out, 32'h80000000);
    chk("post_rst_status", {28'd0, status_out}, 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
